// File: rtl/genesis_pad_pkg.sv
// Shared constants and phase encoding for the Genesis pad reader.
// Button and pin bit positions used by the top level and the samplers.
package genesis_pad_pkg;

  localparam int BTN_W = 12;
  localparam int PIN_W = 6;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  localparam int PIN_UP_Z       = 0;
  localparam int PIN_DOWN_Y     = 1;
  localparam int PIN_LEFT_X     = 2;
  localparam int PIN_RIGHT_MODE = 3;
  localparam int PIN_B_A        = 4;
  localparam int PIN_C_START    = 5;

  typedef enum logic [3:0] {
    IDLE, P0, P1, P2, P3, P4, P5, P6, P7, GAP
  } phase_t;

  function automatic logic sel_level(phase_t s);
    return !(s inside {P1, P3, P5, P7});
  endfunction

endpackage

// File: rtl/genesis_pad_sampler.sv
// Per-port synchroniser, shadow capture, commit masking and
// change detection for one Genesis controller.
module genesis_pad_sampler
  import genesis_pad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] pins_n,
  input  phase_t           phase,
  input  logic             sample,
  input  logic             commit,
  output logic [BTN_W-1:0] buttons,
  output logic             present,
  output logic             six,
  output logic             changed
);

  logic [PIN_W-1:0] s1, s2;
  logic [BTN_W-1:0] sh_btn, masked;
  logic             sh_present, sh_six;

  always_comb begin
    masked = sh_btn;
    if (!sh_six) begin
      masked[BTN_X]    = 1'b0;
      masked[BTN_Y]    = 1'b0;
      masked[BTN_Z]    = 1'b0;
      masked[BTN_MODE] = 1'b0;
    end
    if (!sh_present) masked = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '1;
      s2         <= '1;
      sh_btn     <= '0;
      sh_present <= 1'b0;
      sh_six     <= 1'b0;
      buttons    <= '0;
      present    <= 1'b0;
      six        <= 1'b0;
      changed    <= 1'b0;
    end else begin
      s1      <= pins_n;
      s2      <= s1;
      changed <= 1'b0;
      if (sample) begin
        case (phase)
          P0: begin
            sh_btn[BTN_UP]    <= ~s2[PIN_UP_Z];
            sh_btn[BTN_DOWN]  <= ~s2[PIN_DOWN_Y];
            sh_btn[BTN_LEFT]  <= ~s2[PIN_LEFT_X];
            sh_btn[BTN_RIGHT] <= ~s2[PIN_RIGHT_MODE];
            sh_btn[BTN_B]     <= ~s2[PIN_B_A];
            sh_btn[BTN_C]     <= ~s2[PIN_C_START];
          end
          P1: begin
            sh_btn[BTN_A]     <= ~s2[PIN_B_A];
            sh_btn[BTN_START] <= ~s2[PIN_C_START];
            sh_present <= !s2[PIN_LEFT_X] && !s2[PIN_RIGHT_MODE];
          end
          P5: begin
            sh_six <= !s2[PIN_UP_Z] && !s2[PIN_DOWN_Y] &&
                      !s2[PIN_LEFT_X] && !s2[PIN_RIGHT_MODE];
          end
          P6: begin
            sh_btn[BTN_Z]    <= ~s2[PIN_UP_Z];
            sh_btn[BTN_Y]    <= ~s2[PIN_DOWN_Y];
            sh_btn[BTN_X]    <= ~s2[PIN_LEFT_X];
            sh_btn[BTN_MODE] <= ~s2[PIN_RIGHT_MODE];
          end
          default: ;
        endcase
      end
      if (commit) begin
        buttons <= masked;
        present <= sh_present;
        six     <= sh_six && sh_present;
        changed <= masked != buttons;
      end
    end
  end

endmodule

// File: rtl/genesis_pad_reader.sv
// Multi-port Genesis/Mega Drive pad reader: SELECT sequencer,
// phase timing and frame commit; per-port decode lives in the sampler.
module genesis_pad_reader
  import genesis_pad_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int PHASE_CYCLES = 1000,
  parameter int GAP_CYCLES   = 100000,
  parameter int AUTO_RUN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [6*NUM_PADS-1:0] pad_pins_n,
  output logic [NUM_PADS-1:0]   select_o,
  output logic [12*NUM_PADS-1:0] buttons_o,
  output logic [NUM_PADS-1:0]   present_o,
  output logic [NUM_PADS-1:0]   six_btn_o,
  output logic                  frame_valid_o,
  output logic [NUM_PADS-1:0]   changed_o,
  output logic                  busy_o
);

  localparam int MAX_C = (GAP_CYCLES > PHASE_CYCLES) ?
                         GAP_CYCLES : PHASE_CYCLES;
  localparam int CW = $clog2(MAX_C);

  phase_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic            last, sample, commit;

  always_comb begin
    last = 1'b0;
    case (state)
      IDLE:    last = 1'b0;
      GAP:     last = cnt == CW'(GAP_CYCLES - 1);
      default: last = cnt == CW'(PHASE_CYCLES - 1);
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start_i) nxt = P0;
      GAP:  if (last) nxt = (AUTO_RUN != 0) ? P0 : IDLE;
      P7:   if (last) nxt = GAP;
      default: if (last) nxt = phase_t'(state + 4'd1);
    endcase
  end

  assign sample = last && (state != GAP) && (state != IDLE);
  assign commit = last && (state == P7);
  assign busy_o = state != IDLE;

  // Counter restarts on every state change so each phase is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= GAP;
      cnt           <= '0;
      select_o      <= '1;
      frame_valid_o <= 1'b0;
    end else begin
      state         <= nxt;
      frame_valid_o <= commit;
      select_o      <= {NUM_PADS{sel_level(nxt)}};
      if (nxt != state || state == IDLE) cnt <= '0;
      else cnt <= cnt + 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    genesis_pad_sampler u_smp (
      .clk     (clk),
      .rst     (rst),
      .pins_n  (pad_pins_n[6*p +: 6]),
      .phase   (state),
      .sample  (sample),
      .commit  (commit),
      .buttons (buttons_o[12*p +: 12]),
      .present (present_o[p]),
      .six     (six_btn_o[p]),
      .changed (changed_o[p])
    );
  end

endmodule

// File: tb/tb_genesis_pad_reader.sv
// Bench for genesis_pad_reader: free-run and triggered instances
// driven by behavioural 3/6-button pad models.
module tb_genesis_pad_reader;

  localparam int NP = 2;
  localparam int PH = 8;
  localparam int GP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_t, start, start_a;
  logic [6*NP-1:0]  pins_a, pins_t;
  logic [NP-1:0]    sel_a, pres_a, six_a, chg_a;
  logic [NP-1:0]    sel_t, pres_t, six_t, chg_t;
  logic [12*NP-1:0] btn_a, btn_t;
  logic fv_a, busy_a, fv_t, busy_t;

  genesis_pad_reader #(
    .NUM_PADS(NP), .PHASE_CYCLES(PH),
    .GAP_CYCLES(GP), .AUTO_RUN(1)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_a),
    .pad_pins_n(pins_a), .select_o(sel_a),
    .buttons_o(btn_a), .present_o(pres_a),
    .six_btn_o(six_a), .frame_valid_o(fv_a),
    .changed_o(chg_a), .busy_o(busy_a)
  );

  genesis_pad_reader #(
    .NUM_PADS(NP), .PHASE_CYCLES(PH),
    .GAP_CYCLES(GP), .AUTO_RUN(0)
  ) dut_t (
    .clk(clk), .rst(rst_t), .start_i(start),
    .pad_pins_n(pins_t), .select_o(sel_t),
    .buttons_o(btn_t), .present_o(pres_t),
    .six_btn_o(six_t), .frame_valid_o(fv_t),
    .changed_o(chg_t), .busy_o(busy_t)
  );

  int checks = 0;
  int failures = 0;

  // Pad channels 0,1 -> dut; 2,3 -> dut_t. typ: 0 none, 1 3-btn, 2 6-btn.
  int          typ[4] = '{default: 0};
  logic [11:0] pb[4]  = '{default: 12'h0};
  int          e[4]   = '{default: 0};
  int          hic[4] = '{default: 0};
  logic        prv[4] = '{default: 1'b1};
  logic [11:0] prev_a[2] = '{default: 12'h0};
  logic [11:0] prev_t[2] = '{default: 12'h0};
  int          fv_cnt_t = 0;
  int          sel_low_t = 0;
  logic [NP-1:0] chg_cap_t = '0;

  function automatic logic sel_of(int c);
    return (c < 2) ? sel_a[c] : sel_t[c-2];
  endfunction

  // Pad-side view of SELECT: edge count since the last long high idle.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (sel_of(c) !== prv[c]) begin
        e[c]   <= e[c] + 1;
        hic[c] <= 0;
      end else if (sel_of(c)) begin
        hic[c] <= hic[c] + 1;
        if (hic[c] >= 12) e[c] <= 0;
      end
      prv[c] <= sel_of(c);
    end
    if (fv_t) fv_cnt_t <= fv_cnt_t + 1;
    if (fv_t) chg_cap_t <= chg_t;
    if (!rst_t && sel_t != 2'b11) sel_low_t <= sel_low_t + 1;
  end

  function automatic logic [5:0] pad_pins(int t, logic [11:0] b,
                                          int ph, logic s);
    logic [5:0] act;
    if (t == 0) return 6'h3F;
    if (s)
      act = (t == 2 && ph == 6) ?
            {b[6], b[5], b[11], b[7], b[8], b[9]} :
            {b[6], b[5], b[3], b[2], b[1], b[0]};
    else if (t == 2 && ph == 5)
      act = {b[10], b[4], 4'hF};
    else if (t == 2 && ph == 7)
      act = {b[10], b[4], 4'h0};
    else
      act = {b[10], b[4], 2'b11, b[1], b[0]};
    return ~act;
  endfunction

  always_comb begin
    pins_a = {pad_pins(typ[1], pb[1], e[1], sel_a[1]),
              pad_pins(typ[0], pb[0], e[0], sel_a[0])};
    pins_t = {pad_pins(typ[3], pb[3], e[3], sel_t[1]),
              pad_pins(typ[2], pb[2], e[2], sel_t[0])};
  end

  function automatic logic [11:0] exp_of(int t, logic [11:0] b);
    if (t == 0) return 12'h000;
    if (t == 1) return b & 12'h47F;
    return b;
  endfunction

  function automatic logic [11:0] rnd_btn(int t);
    logic [11:0] r;
    r = 12'($urandom);
    if (t == 1 && r[0] && r[1]) r[0] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a();
    logic [11:0] x;
    for (int p = 0; p < 2; p++) begin
      x = exp_of(typ[p], pb[p]);
      chk($sformatf("btn_a%0d", p), 32'(btn_a[12*p +: 12]), 32'(x));
      chk($sformatf("pres_a%0d", p), 32'(pres_a[p]), 32'(typ[p] != 0));
      chk($sformatf("six_a%0d", p), 32'(six_a[p]), 32'(typ[p] == 2));
      chk($sformatf("chg_a%0d", p), 32'(chg_a[p]), 32'(x != prev_a[p]));
      prev_a[p] = x;
    end
  endtask

  task automatic check_t();
    logic [11:0] x;
    for (int p = 0; p < 2; p++) begin
      x = exp_of(typ[p+2], pb[p+2]);
      chk($sformatf("btn_t%0d", p), 32'(btn_t[12*p +: 12]), 32'(x));
      chk($sformatf("pres_t%0d", p), 32'(pres_t[p]), 32'(typ[p+2] != 0));
      chk($sformatf("six_t%0d", p), 32'(six_t[p]), 32'(typ[p+2] == 2));
      chk($sformatf("chg_t%0d", p), 32'(chg_cap_t[p]),
          32'(x != prev_t[p]));
      prev_t[p] = x;
    end
  endtask

  task automatic next_a();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fv_a && n < 400);
    chk("period_a", 32'(n), 32'(8*PH + GP));
    check_a();
  endtask

  task automatic fresh_frame_a();
    logic es;
    int m;
    for (int n = 1; n <= 80; n++) begin
      step();
      m = n + 1;
      es = (m <= 16 || m > 80) ? 1'b1 : (((m - 17) / 8) % 2 == 0);
      chk($sformatf("sel_fv_c%0d", m), 32'({sel_a, fv_a}),
          32'({{2{es}}, m == 81}));
    end
    check_a();
  endtask

  initial begin
    rst = 1'b1; rst_t = 1'b1; start = 1'b0; start_a = 1'b0;
    typ[0] = 2; pb[0] = 12'h210;
    typ[1] = 0; pb[1] = 12'hFFF;
    repeat (3) step();
    chk("rst_sel_a", 32'(sel_a), 32'h3);
    chk("rst_btn_a", 32'(btn_a), 32'h0);
    chk("rst_pres_six", 32'({pres_a, six_a}), 32'h0);
    chk("rst_fv_chg", 32'({fv_a, chg_a}), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h1);
    chk("rst_busy_t", 32'(busy_t), 32'h1);

    rst = 1'b0;
    fresh_frame_a();

    typ[0] = 1;
    next_a();
    chk("btn3_val", 32'(btn_a[11:0]), 32'h010);

    for (int f = 0; f < 8; f++) begin
      typ[0] = int'($urandom_range(1, 2));
      typ[1] = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) pb[0] = rnd_btn(typ[0]);
      if ($urandom_range(0, 3) != 0) pb[1] = rnd_btn(typ[1]);
      next_a();
    end

    typ[0] = 2; pb[0] = 12'h000;
    next_a();
    pb[0] = 12'h001; next_a();
    next_a();
    pb[0] = 12'h000; next_a();
    next_a();
    chk("busy_auto", 32'(busy_a), 32'h1);

    repeat (50) step();
    chk("p4_sel", 32'(sel_a), 32'h3);
    pb[0] = rnd_btn(2); typ[1] = 1; pb[1] = rnd_btn(1);
    rst = 1'b1;
    step();
    chk("mid_rst_sel", 32'(sel_a), 32'h3);
    chk("mid_rst_btn", 32'(btn_a), 32'h0);
    chk("mid_rst_flags", 32'({pres_a, six_a, fv_a, chg_a}), 32'h0);
    prev_a[0] = 12'h0; prev_a[1] = 12'h0;
    rst = 1'b0;
    fresh_frame_a();

    typ[2] = 2; pb[2] = rnd_btn(2);
    typ[3] = 1; pb[3] = rnd_btn(1);
    step();
    rst_t = 1'b0;
    repeat (40) step();
    chk("t_idle_busy", 32'(busy_t), 32'h0);
    chk("t_idle_sel", 32'(sel_low_t), 32'h0);
    chk("t_idle_fv", 32'(fv_cnt_t), 32'h0);
    start = 1'b1; step(); start = 1'b0; step();
    chk("t_busy", 32'(busy_t), 32'h1);
    repeat (26) step();
    chk("t_p3_sel", 32'(sel_t), 32'h0);
    start = 1'b1; step(); start = 1'b0;
    repeat (150) step();
    chk("t_fv_one", 32'(fv_cnt_t), 32'h1);
    chk("t_done_busy", 32'(busy_t), 32'h0);
    check_t();

    pb[2] = rnd_btn(2) ^ 12'h800; pb[3] = rnd_btn(1);
    start = 1'b1; step(); start = 1'b0;
    repeat (150) step();
    chk("t_fv_two", 32'(fv_cnt_t), 32'h2);
    check_t();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/genesis_pad_reader.md
Name: genesis_pad_reader

Overview:
- Multi-pad Sega Genesis/Mega Drive controller reader.
- Drives one shared SELECT line pattern to NUM_PADS DB9 ports and decodes 3- and 6-button pads.
- Detects pad presence and pad type, and publishes coherent per-frame button snapshots to game logic.
- Adds an idle gap that resets the 6-button pad's internal counter, free-run and triggered modes, input synchronisers and change detection.

Parameters:
- NUM_PADS, 2, number of controller ports, 1..4.
- PHASE_CYCLES, 1000, clk cycles per SELECT phase (20 us at 50 MHz); must be >= 4.
- GAP_CYCLES, 100000, idle cycles with SELECT high after phase 7 (2 ms at 50 MHz; pad needs >= 1.5 ms).
- AUTO_RUN, 1, 1 = frames repeat back-to-back; 0 = a frame starts only on start_i.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  frame request pulse; used only when AUTO_RUN=0, ignored while busy_o=1.
- pad_pins_n  in  6*NUM_PADS  raw DB9 pins, active-low. Per pad p, bits [6p+5:6p] = {c_start, b_a, right_mode, left_x, down_y, up_z}.
- select_o  out  NUM_PADS  SELECT (pin 7) per port; all bits identical.
- buttons_o  out  12*NUM_PADS  active-high buttons, pad p at [12p+11:12p]. Bit map: 0 Up, 1 Down, 2 Left, 3 Right, 4 A, 5 B, 6 C, 7 X, 8 Y, 9 Z, 10 Start, 11 Mode.
- present_o  out  NUM_PADS  pad connected, per last frame.
- six_btn_o  out  NUM_PADS  pad identified as 6-button, per last frame.
- frame_valid_o  out  1  one-cycle pulse, high in the cycle the outputs above update.
- changed_o  out  NUM_PADS  one-cycle pulse with frame_valid_o when that pad's buttons_o differs from the previous snapshot.
- busy_o  out  1  high from P0 to the end of GAP.

Behaviour:
- Input sync: each pad pin passes through 2 flops before use.
- FSM states: IDLE, P0..P7, GAP.
  - SELECT is high in IDLE, P0, P2, P4, P6 and GAP; low in P1, P3, P5, P7.
  - select_o is registered and changes in the first cycle of each phase.
- Phase counter: 0..PHASE_CYCLES-1 in P0..P7, 0..GAP_CYCLES-1 in GAP; cleared on every state change.
- Each Pn lasts exactly PHASE_CYCLES cycles. GAP lasts exactly GAP_CYCLES cycles.
- After GAP: go to P0 if AUTO_RUN=1, otherwise go to IDLE.
- IDLE: go to P0 the cycle after start_i=1. start_i during P0..GAP is dropped, not queued.
- Sampling: synchronised pins are sampled on the last cycle of a phase into per-pad shadow registers. Captured value = ~pin.
  - P0: Up, Down, Left, Right, B, C.
  - P1: A, Start; present = (left_x==0 && right_mode==0).
  - P5: six = (up_z==0 && down_y==0 && left_x==0 && right_mode==0).
  - P6: Z = ~up_z, Y = ~down_y, X = ~left_x, Mode = ~right_mode.
- Commit: on the last cycle of P7, shadow values are copied to the outputs for all pads simultaneously. frame_valid_o=1 in the following cycle, together with the new outputs.
- Masking at commit:
  - If six=0, bits 7, 8, 9, 11 are forced to 0.
  - If present=0, all 12 bits are forced to 0 and six_btn_o is forced to 0.
- changed_o[p] compares the new masked value with the previous buttons_o[p].
- Frame period in AUTO_RUN mode: 8*PHASE_CYCLES + GAP_CYCLES.
- Reset values:
  - FSM state = GAP with counter 0, so the pad counter is reset before the first frame.
  - select_o = all 1; buttons_o, present_o, six_btn_o, changed_o, frame_valid_o = 0.
  - busy_o = 1 during the initial GAP.
  - Synchronisers reset to 1 (released).
- rst asserted mid-frame: the frame is aborted, outputs are cleared, and nothing is committed.
- The snapshot never mixes two frames; outputs hold their value between commits.

Decomposition:
- Package genesis_pad_pkg holds:
  - button bit-index constants, BTN_UP..BTN_MODE;
  - pin-index constants, PIN_UP_Z..PIN_C_START;
  - phase enum, IDLE/P0..P7/GAP;
  - widths for the 12-bit button vector and the 6-bit pin group.
- Sub-module genesis_pad_sampler, one instance per pad, contains the synchroniser, shadow registers, masking, output register and change detect. Inputs: phase, sample strobe, commit strobe.
- The top level owns the FSM, counter, SELECT generation and frame_valid_o.

Test Plan:
- Directed run with PHASE_CYCLES=8, GAP_CYCLES=16, AUTO_RUN=1, 6-button pad model with A+Z held on pad 0 -> select_o shows the H/L pattern with 8-cycle phases and a 16-cycle high gap. At frame_valid_o: buttons_o[11:0]=12'h210, six_btn_o[0]=1, present_o[0]=1, changed_o[0]=1.
- Reset-value check -> after reset, first frame_valid_o occurs 16+64+1 cycles after reset release.
- Same A+Z press on a 3-button pad model -> buttons_o[11:0]=12'h010 (Z masked), six_btn_o[0]=0.
- Pad 1 pins all floating high -> present_o[1]=0 and buttons_o[23:12]=0. Pad 0 is unaffected.
- AUTO_RUN=0 -> no SELECT activity until start_i. start_i pulsed again during P3 is ignored. Exactly one frame_valid_o pulse per accepted start.
- Toggle Up between frames -> changed_o[0] pulses only on frames where the value differs. rst asserted in P4 -> select_o=all 1 next cycle, buttons_o cleared, no frame_valid_o until a full new frame completes.
